// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/datapath-side bundle for the PC sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  i_Stall;
    logic [31:0]           i_Instruction;
    logic                  i_Branch;
    logic [1:0]            i_BranchType;
    logic                  i_Zero;
    logic                  i_Negative;
    logic                  i_Jump;
    logic                  i_Link;
    logic                  i_JumpReg;
    logic [ADDR_WIDTH-1:0] i_RegTarget;
    logic [ADDR_WIDTH-1:0] o_Pc;
    logic [ADDR_WIDTH-1:0] o_PcPlus4;
    logic                  o_Redirect;
    logic                  o_RasValid;
    logic [ADDR_WIDTH-1:0] o_RasTop;
    logic                  o_RasMiss;

    modport master (
        output i_Stall, i_Instruction, i_Branch, i_BranchType, i_Zero, i_Negative,
               i_Jump, i_Link, i_JumpReg, i_RegTarget,
        input  o_Pc, o_PcPlus4, o_Redirect, o_RasValid, o_RasTop, o_RasMiss
    );

    modport slave (
        input  i_Stall, i_Instruction, i_Branch, i_BranchType, i_Zero, i_Negative,
               i_Jump, i_Link, i_JumpReg, i_RegTarget,
        output o_Pc, o_PcPlus4, o_Redirect, o_RasValid, o_RasTop, o_RasMiss
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered MIPS PC with branch/jump/JR selection and a return-address stack checking JR targets.
module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    RAS_DEPTH    = 4
) (
    input logic           i_Clk,
    input logic           i_Rst,
    pc_sequencer_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc4_q, pc4_d;
    logic [ADDR_WIDTH-1:0] br_tgt, j_tgt, jr_tgt, ras_top;
    logic [ADDR_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]         top_q, top_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  redirect_q, redirect_d, miss_q, miss_d;
    logic                  taken, sel_br, sel_j, sel_jr, push, pop, miss;
    logic [31:0]           off, pc4_ext, jfull;
    logic                  unused_bits;

    assign unused_bits = ^{bus.i_Instruction[31:26], bus.i_RegTarget[1:0]};

    always_comb begin
        taken = bus.i_BranchType[1]
              ? (bus.i_BranchType[0] ? !bus.i_Zero && !bus.i_Negative : bus.i_Zero || bus.i_Negative)
              : (bus.i_BranchType[0] ? !bus.i_Zero : bus.i_Zero);
        off     = {{14{bus.i_Instruction[15]}}, bus.i_Instruction[15:0], 2'b00};
        pc4_ext = 32'(pc4_q);
        // Upper PC bits only survive when the address is wider than the 28-bit jump span
        jfull   = {pc4_ext[31:28], bus.i_Instruction[25:0], 2'b00};
        br_tgt  = pc4_q + off[ADDR_WIDTH-1:0];
        j_tgt   = jfull[ADDR_WIDTH-1:0];
        jr_tgt  = {bus.i_RegTarget[ADDR_WIDTH-1:2], 2'b00};
        ras_top = cnt_q != '0 ? ras_q[top_q] : '0;
        sel_br  = bus.i_Branch && taken;
        sel_j   = !sel_br && bus.i_Jump;
        sel_jr  = !sel_br && !bus.i_Jump && bus.i_JumpReg;
        push    = !bus.i_Stall && sel_j && bus.i_Link;
        pop     = !bus.i_Stall && sel_jr;
        miss    = pop && (cnt_q == '0 || jr_tgt != ras_top);
        pc_d    = bus.i_Stall ? pc_q : sel_br ? br_tgt : sel_j ? j_tgt : sel_jr ? jr_tgt : pc4_q;
        pc4_d   = pc_d + FOUR;
        redirect_d = bus.i_Stall ? redirect_q : sel_br || sel_j || sel_jr;
        miss_d  = bus.i_Stall ? miss_q : miss;
        top_d   = push ? top_q + PW'(1) : pop && cnt_q != '0 ? top_q - PW'(1) : top_q;
        cnt_d   = push ? (cnt_q == FULL ? cnt_q : cnt_q + CW'(1))
                : pop && cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
        ras_d   = ras_q;
        // A full stack simply wraps the pointer, overwriting the oldest entry
        if (push) ras_d[top_d] = pc4_q;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pc_q       <= RESET_VECTOR;
            pc4_q      <= RESET_VECTOR + FOUR;
            redirect_q <= 1'b0;
            miss_q     <= 1'b0;
            top_q      <= '0;
            cnt_q      <= '0;
            ras_q      <= '{default: '0};
        end else begin
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            redirect_q <= redirect_d;
            miss_q     <= miss_d;
            top_q      <= top_d;
            cnt_q      <= cnt_d;
            ras_q      <= ras_d;
        end
    end

    assign bus.o_Pc       = pc_q;
    assign bus.o_PcPlus4  = pc4_q;
    assign bus.o_Redirect = redirect_q;
    assign bus.o_RasMiss  = miss_q;
    assign bus.o_RasValid = cnt_q != '0;
    assign bus.o_RasTop   = ras_top;
endmodule
